ucdp_sync_vec: RTL and testbench

//  - Multi-channel CDC synchronizer for width_p independent async level inputs into tgt_clk_i domain.
//  - Configurable synchronizer depth, per-channel glitch/debounce filter, per-channel edge detection.
//  - Optional sticky edge-capture register with clear.
//  - Used for status/IRQ/GPIO level inputs from foreign clock domains or pads.

---
 rtl/ucdp_sync_vec.sv | 165 ++++++++++++++++
 tb/tb_ucdp_sync_vec.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucdp_sync_vec.sv
// -----------------------------------------------------------------------------
// ucdp_sync_vec
//   Multi-channel synchroniser for width_p independent asynchronous level
//   inputs into the tgt_clk_i domain. Each channel has:
//     - a stages_p deep flop chain,
//     - an optional debounce filter (filt_p > 0) that only accepts a new level
//       once it has been stable for filt_p consecutive cycles,
//     - an edge detector whose polarity is selected by edge_type_p.
//
//   Optional feature macro: UCDP_SYNC_VEC_STICKY_EN
//     defined   -> sticky edge-capture register with per-bit clear (clr_i)
//     undefined -> sticky_o is tied low and clr_i is ignored
//
//   Reset: tgt_rst_i is asynchronous, active-high. Its release is expected to
//   be synchronised to tgt_clk_i by the integrator.
// -----------------------------------------------------------------------------
module ucdp_sync_vec #(
    parameter int unsigned          width_p     = 4,
    parameter int unsigned          stages_p    = 2,
    parameter int unsigned          filt_p      = 0,
    parameter logic [1:0]           edge_type_p = 2'h0,
    parameter logic [width_p-1:0]   rstval_p    = {width_p{1'b0}}
) (
    input  logic               tgt_clk_i,
    input  logic               tgt_rst_i,
    input  logic               dft_mode_scan_shift_i,
    input  logic [width_p-1:0] d_i,
    input  logic [width_p-1:0] clr_i,
    output logic [width_p-1:0] q_o,
    output logic [width_p-1:0] edge_o,
    output logic [width_p-1:0] sticky_o
);

    // -------------------------------------------------------------------------
    // Synchroniser chain: index 0 samples the asynchronous input, the last
    // index is the metastability-settled level used by everything downstream.
    // -------------------------------------------------------------------------
    logic [stages_p-1:0][width_p-1:0] sync_r;
    logic [width_p-1:0]               sync_s;

    // Shift every channel one stage per cycle; reset loads rstval_p everywhere.
    always_ff @(posedge tgt_clk_i or posedge tgt_rst_i) begin
        if (tgt_rst_i) begin
            sync_r <= {stages_p{rstval_p}};
        end else begin
            sync_r <= {sync_r[stages_p-2:0], d_i};
        end
    end

    assign sync_s = sync_r[stages_p-1];

    // -------------------------------------------------------------------------
    // Debounce filter. filt_s is the accepted level of each channel.
    // -------------------------------------------------------------------------
    logic [width_p-1:0] filt_s;

    if (filt_p > 0) begin : g_filt
        localparam int unsigned             cnt_w_lp   = $clog2(filt_p + 1);
        localparam logic [cnt_w_lp-1:0]     cnt_max_lp = cnt_w_lp'(filt_p - 1);
        localparam logic [cnt_w_lp-1:0]     cnt_one_lp = cnt_w_lp'(1);

        logic [width_p-1:0] filt_r;

        for (genvar c = 0; c < width_p; c++) begin : g_ch
            logic [cnt_w_lp-1:0] cnt_r;
            logic [cnt_w_lp-1:0] cnt_nxt_s;
            logic                filt_nxt_s;

            // Next-state for one channel: count consecutive disagreeing
            // cycles, accept the new level when the window is complete.
            // During scan shift the filter is a plain flop behind the chain.
            always_comb begin
                cnt_nxt_s  = cnt_r;
                filt_nxt_s = filt_r[c];
                if (dft_mode_scan_shift_i) begin
                    cnt_nxt_s  = {cnt_w_lp{1'b0}};
                    filt_nxt_s = sync_s[c];
                end else if (sync_s[c] == filt_r[c]) begin
                    cnt_nxt_s  = {cnt_w_lp{1'b0}};
                    filt_nxt_s = filt_r[c];
                end else if (cnt_r == cnt_max_lp) begin
                    cnt_nxt_s  = {cnt_w_lp{1'b0}};
                    filt_nxt_s = sync_s[c];
                end else begin
                    cnt_nxt_s  = cnt_r + cnt_one_lp;
                    filt_nxt_s = filt_r[c];
                end
            end

            // Filter state register; a reset discards any partial window.
            always_ff @(posedge tgt_clk_i or posedge tgt_rst_i) begin
                if (tgt_rst_i) begin
                    cnt_r     <= {cnt_w_lp{1'b0}};
                    filt_r[c] <= rstval_p[c];
                end else begin
                    cnt_r     <= cnt_nxt_s;
                    filt_r[c] <= filt_nxt_s;
                end
            end
        end

        assign filt_s = filt_r;
    end else begin : g_nofilt
        // Without a filter the settled level is used directly, so scan shift
        // has nothing to bypass here.
        logic unused_scan_s;

        assign unused_scan_s = dft_mode_scan_shift_i;
        assign filt_s        = sync_s;
    end

    assign q_o = filt_s;

    // -------------------------------------------------------------------------
    // Edge detection against the previous accepted level.
    // -------------------------------------------------------------------------
    logic [width_p-1:0] hist_r;
    logic [width_p-1:0] edge_s;

    // Remember last cycle's accepted level for edge comparison.
    always_ff @(posedge tgt_clk_i or posedge tgt_rst_i) begin
        if (tgt_rst_i) begin
            hist_r <= rstval_p;
        end else begin
            hist_r <= filt_s;
        end
    end

    // Select the edge polarity shared by all channels.
    always_comb begin
        edge_s = {width_p{1'b0}};
        case (edge_type_p)
            2'h1:    edge_s = ~hist_r & filt_s;
            2'h2:    edge_s = hist_r & ~filt_s;
            2'h3:    edge_s = hist_r ^ filt_s;
            default: edge_s = {width_p{1'b0}};
        endcase
    end

    assign edge_o = edge_s;

    // -------------------------------------------------------------------------
    // Optional sticky capture of edge pulses.
    // -------------------------------------------------------------------------
`ifdef UCDP_SYNC_VEC_STICKY_EN
    logic [width_p-1:0] sticky_r;

    // Capture edges, clear on request; a new edge beats a same-cycle clear.
    always_ff @(posedge tgt_clk_i or posedge tgt_rst_i) begin
        if (tgt_rst_i) begin
            sticky_r <= {width_p{1'b0}};
        end else begin
            sticky_r <= (sticky_r & ~clr_i) | edge_s;
        end
    end

    assign sticky_o = sticky_r;
`else
    logic [width_p-1:0] unused_clr_s;

    assign unused_clr_s = clr_i;
    assign sticky_o     = {width_p{1'b0}};
`endif

endmodule

// File: tb/tb_ucdp_sync_vec.sv
// -----------------------------------------------------------------------------
// tb_ucdp_sync_vec
//   Two instances share the stimulus: a filtered any-edge channel set
//   (stages 2, filter 3) and an unfiltered rising-edge one (stages 2).
//   A behavioural model derives the expected outputs from the input history;
//   a compare process checks both instances every cycle, and directed steps
//   add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_ucdp_sync_vec;

    localparam int ST = 2;
    localparam int FL = 3;

`ifdef UCDP_SYNC_VEC_STICKY_EN
    localparam logic [3:0] STK2 = 4'h2;
`else
    localparam logic [3:0] STK2 = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scan;
    logic [3:0] d;
    logic [3:0] clr;
    logic [3:0] q, e, sk;
    logic [3:0] q_b, e_b, sk_b;

    always #5 clk = ~clk;

    ucdp_sync_vec #(
        .width_p(4), .stages_p(2), .filt_p(3), .edge_type_p(2'h3), .rstval_p(4'h0)
    ) dut (
        .tgt_clk_i(clk), .tgt_rst_i(rst), .dft_mode_scan_shift_i(scan),
        .d_i(d), .clr_i(clr), .q_o(q), .edge_o(e), .sticky_o(sk)
    );

    ucdp_sync_vec #(
        .width_p(4), .stages_p(2), .filt_p(0), .edge_type_p(2'h1), .rstval_p(4'h0)
    ) dut_byp (
        .tgt_clk_i(clk), .tgt_rst_i(rst), .dft_mode_scan_shift_i(scan),
        .d_i(d), .clr_i(clr), .q_o(q_b), .edge_o(e_b), .sticky_o(sk_b)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] d_hist [0:4095];
    int         n         = 0;
    int         win_start = 0;
    logic [3:0] f_m, p_m, st_m;
    logic [3:0] qb_m, pb_m, stb_m;

    // Settled level seen just before clock edge k (input sampled ST edges earlier).
    function automatic logic [3:0] s_b(input int k);
        if (k - ST < 0) return 4'h0;
        return d_hist[k - ST];
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] nf, e_old, eb_old, sv;
        bit         ok;
        if (rst) begin
            n = 0; win_start = 0;
            f_m = 4'h0; p_m = 4'h0; st_m = 4'h0;
            qb_m = 4'h0; pb_m = 4'h0; stb_m = 4'h0;
        end else begin
            d_hist[n] = d;
            e_old  = p_m ^ f_m;
            eb_old = ~pb_m & qb_m;
            nf     = f_m;
            if (scan) begin
                nf        = s_b(n);
                win_start = n + 1;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    ok = (n - FL + 1 >= win_start);
                    for (int j = 0; j < FL; j++) begin
                        sv = s_b(n - j);
                        if (sv[b] == f_m[b]) ok = 1'b0;
                    end
                    if (ok) nf[b] = ~f_m[b];
                end
            end
`ifdef UCDP_SYNC_VEC_STICKY_EN
            st_m  = (st_m & ~clr) | e_old;
            stb_m = (stb_m & ~clr) | eb_old;
`endif
            p_m  = f_m;
            f_m  = nf;
            pb_m = qb_m;
            qb_m = s_b(n + 1);
            if (n < 4095) n = n + 1;
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", q, f_m);
            chk("edge", e, p_m ^ f_m);
            chk("sticky", sk, st_m);
            chk("q_byp", q_b, qb_m);
            chk("edge_byp", e_b, ~pb_m & qb_m);
            chk("sticky_byp", sk_b, stb_m);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    logic       seen_q, seen_e, found;
    logic [3:0] sv_d [0:15];

    initial begin
        rst = 1'b1; scan = 1'b0; d = 4'hF; clr = 4'h0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        chk("rst_q", q, 4'h0);
        chk("rst_edge", e, 4'h0);
        chk("rst_sticky", sk, 4'h0);

        // Release with all inputs high: q rises exactly 5 clocks later.
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 4) chk("lat_q4", q, 4'h0);
            if (k == 5) begin
                chk("lat_q5", q, 4'hF);
                chk("lat_e5", e, 4'hF);
            end
            if (k == 6) chk("lat_e6", e, 4'h0);
        end

        // Glitch rejection on bit 0.
        d = 4'hE;
        tick(8);
        chk("glitch_pre", q, 4'hE);
        d = 4'hF;
        tick(2);
        d = 4'hE;
        seen_q = 1'b0; seen_e = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            seen_q = seen_q | q[0];
            seen_e = seen_e | e[0];
        end
        chk("glitch2_q", {3'b000, seen_q}, 4'h0);
        chk("glitch2_e", {3'b000, seen_e}, 4'h0);
        d = 4'hF;
        tick(3);
        d = 4'hE;
        seen_q = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            seen_q = seen_q | q[0];
        end
        chk("glitch3_q", {3'b000, seen_q}, 4'h1);

        // Sticky capture and clear on bit 1.
        clr = 4'hF;
        tick(1);
        clr = 4'h0;
        chk("stk_clr", sk, 4'h0);
        d = 4'hC;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick(1);
            if (e[1]) found = 1'b1;
        end
        chk("stk_edge1_seen", {3'b000, found}, 4'h1);
        tick(1);
        chk("stk_set", sk, STK2);
        d = 4'hE;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick(1);
            if (e[1]) found = 1'b1;
        end
        chk("stk_edge2_seen", {3'b000, found}, 4'h1);
        clr = 4'h2;
        tick(1);
        chk("stk_edge_wins", sk, STK2);
        clr = 4'h2;
        tick(1);
        chk("stk_cleared", sk, 4'h0);
        clr = 4'h0;

        // Reset in the middle of a filter window on bit 3.
        d = 4'h6;
        tick(8);
        chk("mid_pre", q, 4'h6);
        d = 4'hE;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_q", q, 4'h0);
        chk("mid_rst_e", e, 4'h0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k == 4) chk("mid_q3_k4", q & 4'h8, 4'h0);
            if (k == 5) chk("mid_q3_k5", q & 4'h8, 4'h8);
        end
        tick(4);

        // Scan shift: filter becomes a single flop, bit 1 toggles each cycle.
        scan = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d[1]    = i[0];
            sv_d[i] = d;
            tick(1);
            if (i >= 2) chk("scan_q1", {3'b000, q[1]}, {3'b000, sv_d[i-2][1]});
        end
        scan = 1'b0;
        d    = 4'hE;
        tick(10);

        // Unfiltered instance: rising edge pulses, falling edge does not.
        d = 4'hA;
        tick(4);
        d = 4'hE;
        tick(1);
        chk("byp_q2_t1", q_b & 4'h4, 4'h0);
        tick(1);
        chk("byp_q2_t2", q_b & 4'h4, 4'h4);
        chk("byp_e2_t2", e_b & 4'h4, 4'h4);
        tick(1);
        chk("byp_e2_t3", e_b & 4'h4, 4'h0);
        d = 4'hA;
        seen_e = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            seen_e = seen_e | e_b[2];
        end
        chk("byp_fall_e", {3'b000, seen_e}, 4'h0);
        chk("byp_fall_q", q_b & 4'h4, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
